// File: rtl/mem_cmd_gen_if.sv
// Avalon-MM master bus bundle for the memory command generator.
// The master drives command fields; the slave returns waitrequest.
interface mem_cmd_gen_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic                read;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest
    );
endinterface

// File: rtl/mem_cmd_gen.sv
// Avalon-MM command generator: sequential/LFSR addresses, pattern/LFSR data,
// single output stage with snapshot/restore for write-all-then-check-all.
module mem_cmd_gen #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              restore_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              addr_mode_i,
    input  logic              data_mode_i,
    input  logic [7:0]        pattern_i,
    input  logic              rd_same_addr_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic              cmd_ready_o,
    output logic              cmd_accepted_o,
    output logic [ADDR_W-1:0] last_addr_o,
    mem_cmd_gen_if.master     amm
);

    localparam logic [31:0] POLY   = 32'h8020_0003;
    localparam logic [31:0] SEED_A = 32'h0000_0001;
    localparam logic [31:0] SEED_D = 32'hACE1_ACE1;

    // Right-shift Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    logic [ADDR_W-1:0] base_q;
    logic              amode_q;
    logic              dmode_q;
    logic [7:0]        pat_q;
    logic [ADDR_W-1:0] seq_q;
    logic [31:0]       alfsr_q;
    logic [31:0]       dlfsr_q;
    logic [ADDR_W-1:0] wraddr_q;

    logic              busy;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic              rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic              acc_q;
    logic [ADDR_W-1:0] last_q;

    logic              cap;
    logic              done;
    logic              advance;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] gen_data;

    assign gen_addr = amode_q ? base_q + alfsr_q[ADDR_W-1:0] : seq_q;
    assign cmd_addr = (wr_en_i | ~rd_same_addr_i) ? gen_addr : wraddr_q;
    assign gen_data = dmode_q ? {(DATA_W/32){dlfsr_q}}
                              : {(DATA_W/8){pat_q}};

    assign cmd_ready_o = (~busy | ~amm.waitrequest) & ~start_i & ~restore_i;
    assign cap         = cmd_ready_o & (wr_en_i | rd_en_i);
    assign done        = busy & ~amm.waitrequest;
    assign advance     = cap & (wr_en_i | ~rd_same_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q   <= '0;
            amode_q  <= 1'b0;
            dmode_q  <= 1'b0;
            pat_q    <= '0;
            seq_q    <= '0;
            alfsr_q  <= SEED_A;
            dlfsr_q  <= SEED_A;
            wraddr_q <= '0;
        end else if (start_i) begin
            base_q  <= base_addr_i;
            amode_q <= addr_mode_i;
            dmode_q <= data_mode_i;
            pat_q   <= pattern_i;
            seq_q   <= base_addr_i;
            alfsr_q <= SEED_A;
            dlfsr_q <= SEED_D;
        end else if (restore_i) begin
            // Mode and pattern are unchanged since start, so only the
            // generator state needs reloading to replay the sequence.
            seq_q   <= base_q;
            alfsr_q <= SEED_A;
            dlfsr_q <= SEED_D;
        end else begin
            if (advance) begin
                seq_q   <= seq_q + ADDR_W'(1);
                alfsr_q <= lfsr_next(alfsr_q);
            end
            if (cap && wr_en_i) begin
                dlfsr_q  <= lfsr_next(dlfsr_q);
                wraddr_q <= gen_addr;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy    <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            acc_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            acc_q <= done;
            if (done) begin
                last_q <= addr_q;
            end
            if (cap) begin
                busy    <= 1'b1;
                addr_q  <= cmd_addr;
                wr_q    <= wr_en_i;
                rd_q    <= ~wr_en_i;
                wdata_q <= gen_data;
            end else if (done) begin
                busy <= 1'b0;
                wr_q <= 1'b0;
                rd_q <= 1'b0;
            end
        end
    end

    assign amm.address     = addr_q;
    assign amm.write       = wr_q;
    assign amm.read        = rd_q;
    assign amm.writedata   = wdata_q;
    assign amm.byteenable  = '1;
    assign cmd_accepted_o  = acc_q;
    assign last_addr_o     = last_q;

endmodule

// File: tb/tb_mem_cmd_gen.sv
// Self-checking bench for mem_cmd_gen: scoreboard of expected Avalon commands
// built from a reference generator model, plus directed protocol checks.
module tb_mem_cmd_gen;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam logic [31:0] POLY = 32'h8020_0003;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    logic start, restore, amode, dmode, rd_same, wr_en, rd_en;
    logic [AW-1:0] base;
    logic [7:0]    pat;
    logic          cmd_ready, cmd_acc;
    logic [AW-1:0] last_addr;

    mem_cmd_gen_if #(.ADDR_W(AW), .DATA_W(DW)) amm ();

    mem_cmd_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .restore_i      (restore),
        .base_addr_i    (base),
        .addr_mode_i    (amode),
        .data_mode_i    (dmode),
        .pattern_i      (pat),
        .rd_same_addr_i (rd_same),
        .wr_en_i        (wr_en),
        .rd_en_i        (rd_en),
        .cmd_ready_o    (cmd_ready),
        .cmd_accepted_o (cmd_acc),
        .last_addr_o    (last_addr),
        .amm            (amm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference generator model
    logic [AW-1:0] m_base, m_seq, m_wraddr;
    logic          m_amode, m_dmode;
    logic [7:0]    m_pat;
    logic [31:0]   m_alfsr, m_dlfsr;

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ POLY;
        return n;
    endfunction

    cmd_t          sb[$];
    logic [AW-1:0] log_a[$];
    bit            exp_acc = 0;
    logic [AW-1:0] exp_last;
    int            acc_cnt = 0;

    function automatic logic [AW-1:0] m_addr();
        logic [AW-1:0] off;
        off = m_alfsr[AW-1:0];
        return m_amode ? m_base + off : m_seq;
    endfunction

    task automatic model_cap(input bit w, input bit r, input bit s);
        cmd_t c;
        if (!w && !r) return;
        c.wr   = w;
        c.addr = (w || !s) ? m_addr() : m_wraddr;
        c.data = m_dmode ? m_dlfsr : {4{m_pat}};
        sb.push_back(c);
        if (w) m_wraddr = c.addr;
        if (w || !s) begin
            m_seq   = m_seq + 1'b1;
            m_alfsr = step(m_alfsr);
        end
        if (w) m_dlfsr = step(m_dlfsr);
    endtask

    always @(negedge clk) begin
        cmd_t e;
        if (rst) begin
            exp_acc = 0;
        end else begin
            chk("acc", cmd_acc, exp_acc);
            if (exp_acc) chk("last_addr", last_addr, exp_last);
            if (cmd_acc) acc_cnt++;
            exp_acc = 0;
            chk("rw_excl", amm.write & amm.read, 0);
            if ((amm.write || amm.read) && !amm.waitrequest) begin
                if (sb.size() == 0) begin
                    chk("unexp_cmd", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_wr", amm.write, e.wr);
                    chk("cmd_rd", amm.read, !e.wr);
                    chk("addr", amm.address, e.addr);
                    if (e.wr) chk("wdata", amm.writedata, e.data);
                    exp_acc  = 1;
                    exp_last = e.addr;
                    log_a.push_back(amm.address);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input bit am,
                            input bit dm, input logic [7:0] p);
        base  = b; amode = am; dmode = dm; pat = p;
        start = 1;
        m_base = b; m_amode = am; m_dmode = dm; m_pat = p;
        m_seq = b; m_alfsr = 32'h1; m_dlfsr = 32'hACE1_ACE1;
        @(negedge clk);
        chk("ready_start", cmd_ready, 0);
        tick();
        start = 0;
    endtask

    task automatic do_restore();
        restore = 1;
        m_seq = m_base; m_alfsr = 32'h1; m_dlfsr = 32'hACE1_ACE1;
        @(negedge clk);
        chk("ready_restore", cmd_ready, 0);
        tick();
        restore = 0;
    endtask

    task automatic req(input bit w, input bit r, input bit s);
        wr_en = w; rd_en = r; rd_same = s;
        model_cap(w, r, s);
        tick();
        wr_en = 0; rd_en = 0; rd_same = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int a0;
        rst = 1; start = 0; restore = 0; amode = 0; dmode = 0;
        rd_same = 0; wr_en = 0; rd_en = 0; base = '0; pat = '0;
        amm.waitrequest = 0;
        m_base = '0; m_seq = '0; m_wraddr = '0; m_amode = 0; m_dmode = 0;
        m_pat = '0; m_alfsr = 32'h1; m_dlfsr = 32'h1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        chk("rst_write", amm.write, 0);
        chk("rst_read", amm.read, 0);
        chk("rst_addr", amm.address, 0);
        chk("rst_wdata", amm.writedata, 0);
        chk("rst_be", amm.byteenable, 4'hF);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_last", last_addr, 0);
        tick();

        // Sequential writes across the address wrap
        do_start(25'h1FF_FFFE, 0, 0, 8'hA5);
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) req(1, 0, 0);
        drain();
        chk("seq_acc_cnt", acc_cnt - a0, 4);
        chk("seq_last", last_addr, 25'h000_0001);

        // Waitrequest stall
        amm.waitrequest = 1;
        req(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", cmd_ready, 0);
            chk("stall_write", amm.write, 1);
            chk("stall_addr", amm.address, 25'h000_0002);
            chk("stall_data", amm.writedata, 32'hA5A5_A5A5);
            tick();
        end
        amm.waitrequest = 0;
        drain();

        // Write then read same address, random mode
        do_start(25'h010_0000, 1, 1, 8'h00);
        log_a.delete();
        req(1, 0, 0);
        req(0, 1, 1);
        req(1, 0, 0);
        drain();
        chk("same_n", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("same_w0", log_a[0], 25'h010_0001);
            chk("same_rd", log_a[1], log_a[0]);
            chk("same_w1", log_a[2], 25'h030_0003);
        end

        // Restore replay
        do_start(25'h00A_BCDE, 1, 1, 8'h00);
        log_a.delete();
        for (int i = 0; i < 8; i++) req(1, 0, 0);
        drain();
        do_restore();
        for (int i = 0; i < 8; i++) req(0, 1, 0);
        drain();
        chk("replay_n", log_a.size(), 16);
        if (log_a.size() == 16)
            for (int i = 0; i < 8; i++)
                chk("replay", log_a[8+i], log_a[i]);

        // Both requests high: write wins
        req(1, 1, 0);
        @(negedge clk);
        chk("both_rd", amm.read, 0);
        drain();

        // start while busy
        do_start(25'h000_0040, 0, 0, 8'h3C);
        amm.waitrequest = 1;
        req(1, 0, 0);
        base = 25'h000_0100; amode = 0; dmode = 0; pat = 8'h5A;
        start = 1; wr_en = 1; amm.waitrequest = 0;
        m_base = base; m_amode = 0; m_dmode = 0; m_pat = 8'h5A;
        m_seq = base; m_alfsr = 32'h1; m_dlfsr = 32'hACE1_ACE1;
        @(negedge clk);
        chk("busy_start_ready", cmd_ready, 0);
        tick();
        start = 0; wr_en = 0;
        req(1, 0, 0);
        drain();
        chk("busy_start_last", last_addr, 25'h000_0100);

        // Reset during a stall
        amm.waitrequest = 1;
        req(1, 0, 0);
        @(negedge clk);
        #2 rst = 1;
        #1 chk("rst_stall_write", amm.write, 0);
        sb.delete();
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_stall_ready", cmd_ready, 1);
        chk("rst_stall_idle", amm.write, 0);
        amm.waitrequest = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_cmd_gen.md
# mem_cmd_gen

Avalon-MM command generator that sits directly downstream of the memory-checker control FSM. It accepts single-word write/read requests from the FSM, generates the address (sequential or pseudo-random) and write data (fixed pattern or pseudo-random), and drives the Avalon-MM master port. It reports per-command acceptance back to the FSM. A save/restore mechanism replays the exact address/data sequence for write-all-then-check-all tests.

## Interface
Parameters:
- ADDR_W, 25, Avalon word-address width
- DATA_W, 32, Avalon data width; must be a multiple of 32

Ports:
- clk_i  in  1  single clock for the whole block
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse; loads generators and snapshots their state
- restore_i  in  1  one-cycle pulse; reloads generators from the start_i snapshot
- base_addr_i  in  ADDR_W  starting/offset address, sampled on start_i
- addr_mode_i  in  1  0 = sequential, 1 = pseudo-random; sampled on start_i
- data_mode_i  in  1  0 = fixed pattern, 1 = pseudo-random; sampled on start_i
- pattern_i  in  8  fixed byte, replicated across DATA_W; sampled on start_i
- rd_same_addr_i  in  1  read reuses last write address, generator not advanced
- wr_en_i  in  1  write request from control FSM
- rd_en_i  in  1  read request from control FSM
- cmd_ready_o  out  1  block can take a request this cycle
- cmd_accepted_o  out  1  one-cycle pulse, a command completed on Avalon
- last_addr_o  out  ADDR_W  address of the most recently accepted command
- amm_address_o  out  ADDR_W  Avalon address
- amm_write_o  out  1  Avalon write
- amm_read_o  out  1  Avalon read
- amm_writedata_o  out  DATA_W  Avalon write data
- amm_byteenable_o  out  DATA_W/8  constant all ones
- amm_waitrequest_i  in  1  Avalon waitrequest

## Operation
- **Reset values:**
  - All registered outputs are 0, except amm_byteenable_o, which is all ones.
  - cmd_ready_o = 1 after reset. The block is idle; the address LFSR and the data LFSR both hold 32'h0000_0001.
- **Request capture:**
  - A request is taken when cmd_ready_o & (wr_en_i | rd_en_i) are high at a clock edge.
  - If both wr_en_i and rd_en_i are high, the write is taken and the read is dropped.
- **Output register:** a single output stage.
  - busy is set on capture.
  - busy is cleared when amm_waitrequest_i=0 while busy, unless a new request is captured on the same edge.
  - cmd_ready_o = !busy | !amm_waitrequest_i, gated low in any cycle where start_i or restore_i is high.
- **Avalon rules:**
  - amm_write_o/amm_read_o, address and data are held stable while amm_waitrequest_i=1.
  - Only one of amm_write_o/amm_read_o is high at a time.
- **Sequential address mode:**
  - The generator starts at base_addr_i.
  - It adds 1 per advance, wrapping modulo 2^ADDR_W.
- **Pseudo-random address mode:**
  - Address = (base_addr_i + addr_lfsr[ADDR_W-1:0]) mod 2^ADDR_W.
  - addr_lfsr is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded 32'h0000_0001 on start_i.
- **Address advance:**
  - The generator advances on every captured write.
  - It advances on every captured read, unless rd_same_addr_i=1. In that case the read uses the last captured write address and the generator does not advance.
- **Data:**
  - Mode 0: amm_writedata_o = {DATA_W/8{pattern}}.
  - Mode 1: amm_writedata_o = {DATA_W/32{data_lfsr}}. data_lfsr uses the same polynomial, is seeded 32'hACE1_ACE1, and advances only on captured writes.
- **Snapshot and restore:**
  - start_i stores the initial generator state.
  - restore_i reloads that state, so the next commands reproduce the sequence begun at start_i.
- **start_i/restore_i while busy:**
  - The in-flight Avalon command is completed; it is never dropped.
  - Generator reload happens on the pulse edge.
  - Requests in that cycle are ignored.
- **last_addr_o and cmd_accepted_o:**
  - last_addr_o is updated with amm_address_o when the command completes.
  - cmd_accepted_o pulses in the same registered update.

## Timing
- Capture at edge N puts the command on Avalon during cycle N+1.
- Completion at the first edge M > N with amm_waitrequest_i=0 gives cmd_accepted_o=1 during cycle M+1, for exactly one cycle.
- Throughput: one command per cycle when waitrequest stays low.
  - The FSM holding wr_en_i high for K cycles yields K back-to-back commands.
- cmd_ready_o is combinational from amm_waitrequest_i; there is no other combinational path to the outputs.
- Asynchronous reset mid-transaction deasserts amm_write_o/amm_read_o immediately and discards the pending command.

## Test plan
- **Sequential writes:** base=0x1FFFFFE, mode 0, pattern 0xA5, wr_en_i high for 4 cycles, waitrequest=0 → addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001; data 0xA5A5A5A5; 4 cmd_accepted_o pulses.
- **Waitrequest stall:** single write with waitrequest high for 3 cycles → address/data stable for 4 cycles; cmd_ready_o=0 for 3 cycles; cmd_accepted_o pulses once, 1 cycle after waitrequest drops.
- **Write-then-read, same address:** random address mode, rd_same_addr_i=1, write then read → read address equals write address; the next write uses the second LFSR address.
- **Restore replay:** random address/data, 8 writes, restore_i, 8 reads → read address sequence is identical to the write address sequence.
- **Protocol edge cases:**
  - wr_en_i and rd_en_i both high → only amm_write_o asserted.
  - start_i while busy → pending command completes; the next command uses the reloaded base address.
- **Reset during stall:** rst_i asserted during a stall → amm_write_o=0 immediately and cmd_ready_o=1 after release.
